// File: rtl/egress_arbiter_pkg.sv
// Shared switch definitions: port counts, AXI-Stream widths, arbiter state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package egress_arbiter_pkg;

    localparam int NUM_INGRESS_PORTS = 4;
    localparam int NUM_EGRESS_PORTS  = 4;
    localparam int AXIS_DATA_WIDTH   = 16;
    localparam int AXIS_DEST_WIDTH   = 2;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Per-port stream bundles; the packet_switch level flattens these onto the arbiter ports.
    typedef struct packed {
        logic [AXIS_DATA_WIDTH-1:0] tdata;
        logic [AXIS_DEST_WIDTH-1:0] tdest;
        logic                       tvalid;
        logic                       tlast;
    } axis_d_source_t;

    typedef struct packed {
        logic tready;
    } axis_sink_t;

endpackage

// File: rtl/egress_arbiter_if.sv
// Ingress/egress AXI-Stream bundle seen by one egress arbiter.
// Latency: n/a (wires only).
// Backpressure: tready flows from the egress side back to the granted ingress port.
//
// master modport: the switch fabric side (drives ingress streams, egress ready).
// slave modport : the arbiter side (drives ingress readies, egress stream).
interface egress_arbiter_if
    import egress_arbiter_pkg::*;
#(
    parameter int NUM_INGRESS = NUM_INGRESS_PORTS,
    parameter int DATA_WIDTH  = AXIS_DATA_WIDTH,
    parameter int DEST_WIDTH  = AXIS_DEST_WIDTH
);
    logic [NUM_INGRESS*DATA_WIDTH-1:0] in_tdata;
    logic [NUM_INGRESS*DEST_WIDTH-1:0] in_tdest;
    logic [NUM_INGRESS-1:0]            in_tvalid;
    logic [NUM_INGRESS-1:0]            in_tlast;
    logic [NUM_INGRESS-1:0]            in_tready;
    logic [DATA_WIDTH-1:0]             out_tdata;
    logic                              out_tvalid;
    logic                              out_tlast;
    logic                              out_tready;

    modport master (
        output in_tdata, in_tdest, in_tvalid, in_tlast, out_tready,
        input  in_tready, out_tdata, out_tvalid, out_tlast
    );

    modport slave (
        input  in_tdata, in_tdest, in_tvalid, in_tlast, out_tready,
        output in_tready, out_tdata, out_tvalid, out_tlast
    );
endinterface

// File: rtl/egress_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after rr_ptr, wrapping modulo N.
// Latency: combinational.
// Backpressure: none; pure function of req and rr_ptr.
//
// Ports: req (N requests), rr_ptr (scan start index), onehot/idx (winner), any (some request set).
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);
    always_comb begin
        int j;
        j      = 0;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any       = 1'b1;
                onehot[j] = 1'b1;
                idx       = IW'(j);
            end
        end
    end
endmodule

// File: rtl/egress_arbiter.sv
// Per-egress-port packet arbiter: round-robin over ingress ports whose tdest matches PORT_ID,
// grant held for a whole packet. Latency: 1 cycle request-to-first-beat, 0-cycle beat pass-through.
// Backpressure: out_tready is passed straight to the granted port's in_tready; others see 0.
//
// Ports: clk, reset (async, active-low), enable (egress mask bit), axis (slave modport of
// egress_arbiter_if), busy (packet granted), grant (one-hot, zero when idle).
// Optional macro EGRESS_ARB_PKT_CNT_EN adds pkt_cnt (saturating tlast counter) and pkt_cnt_clr.
module egress_arbiter
    import egress_arbiter_pkg::*;
#(
    parameter  int NUM_INGRESS = NUM_INGRESS_PORTS,
    parameter  int DATA_WIDTH  = AXIS_DATA_WIDTH,
    parameter  int DEST_WIDTH  = AXIS_DEST_WIDTH,
    parameter  int PORT_ID     = 0,
    localparam int IW          = (NUM_INGRESS > 1) ? $clog2(NUM_INGRESS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    egress_arbiter_if.slave        axis,
    output logic                   busy,
    output logic [NUM_INGRESS-1:0] grant
`ifdef EGRESS_ARB_PKT_CNT_EN
    ,
    output logic [15:0]            pkt_cnt,
    input  logic                   pkt_cnt_clr
`endif
);
    arb_state_t             state;
    logic [IW-1:0]          gidx;
    logic [IW-1:0]          rr_ptr;
    logic [NUM_INGRESS-1:0] req;
    logic [NUM_INGRESS-1:0] pick_onehot;
    logic [IW-1:0]          pick_idx;
    logic                   pick_any;
    logic                   last_accept;

    // tdest only matters while idle: once granted, the mux ignores it.
    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_INGRESS; i++) begin
            req[i] = axis.in_tvalid[i] && enable &&
                     (axis.in_tdest[i*DEST_WIDTH +: DEST_WIDTH] == DEST_WIDTH'(PORT_ID));
        end
    end

    rr_pick #(.N(NUM_INGRESS)) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Egress mux and ready return; everything forced to zero while idle.
    always_comb begin
        axis.out_tvalid = 1'b0;
        axis.out_tlast  = 1'b0;
        axis.out_tdata  = '0;
        axis.in_tready  = '0;
        if (state == ARB_BUSY) begin
            axis.out_tvalid = axis.in_tvalid[gidx];
            axis.out_tlast  = axis.in_tlast[gidx];
            axis.out_tdata  = axis.in_tdata[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
            axis.in_tready  = axis.out_tready ? grant : '0;
        end
    end

    assign last_accept = (state == ARB_BUSY) && axis.out_tvalid && axis.out_tready && axis.out_tlast;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ARB_IDLE;
            grant  <= '0;
            gidx   <= '0;
            rr_ptr <= '0;
            busy   <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        state <= ARB_BUSY;
                        grant <= pick_onehot;
                        gidx  <= pick_idx;
                        busy  <= 1'b1;
                    end
                end
                ARB_BUSY: begin
                    // Returning to IDLE forces at least one bubble cycle between packets.
                    if (last_accept) begin
                        state  <= ARB_IDLE;
                        grant  <= '0;
                        busy   <= 1'b0;
                        rr_ptr <= (gidx == IW'(NUM_INGRESS-1)) ? '0 : gidx + IW'(1);
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef EGRESS_ARB_PKT_CNT_EN
    // Clear wins over a same-cycle increment; count sticks at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_cnt <= '0;
        end else if (pkt_cnt_clr) begin
            pkt_cnt <= '0;
        end else if (last_accept && (pkt_cnt != 16'hFFFF)) begin
            pkt_cnt <= pkt_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_egress_arbiter.sv
// Directed bench for egress_arbiter with PORT_ID=2: vector table plus reset and round-robin sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_egress_arbiter;
    import egress_arbiter_pkg::*;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       busy;
    logic [3:0] grant;
`ifdef EGRESS_ARB_PKT_CNT_EN
    logic [15:0] pkt_cnt;
    logic        pkt_cnt_clr;
`endif

    int errors = 0;
    int checks = 0;

    egress_arbiter_if #(.NUM_INGRESS(4), .DATA_WIDTH(16), .DEST_WIDTH(2)) ifc ();

    egress_arbiter #(
        .NUM_INGRESS (4),
        .DATA_WIDTH  (16),
        .DEST_WIDTH  (2),
        .PORT_ID     (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .axis        (ifc),
        .busy        (busy),
        .grant       (grant)
`ifdef EGRESS_ARB_PKT_CNT_EN
        ,
        .pkt_cnt     (pkt_cnt),
        .pkt_cnt_clr (pkt_cnt_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs packed as {out_tvalid, out_tlast, out_tdata, in_tready, busy, grant}.
    typedef struct {
        string       name;
        logic        en;
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic [7:0]  dst;
        logic [63:0] dat;
        logic        rdy;
        logic [26:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [26:0] ex(logic v, logic l, logic [15:0] d, logic [3:0] r,
                                       logic b, logic [3:0] g);
        return {v, l, d, r, b, g};
    endfunction

    function automatic vec_t mkv(string nm, logic en, logic [3:0] vld, logic [3:0] lst,
                                 logic [7:0] dst, logic [63:0] dat, logic rdy, logic [26:0] exp);
        vec_t v;
        v.name = nm; v.en = en; v.vld = vld; v.lst = lst;
        v.dst = dst; v.dat = dat; v.rdy = rdy; v.exp = exp;
        return v;
    endfunction

    task automatic drive(logic en, logic [3:0] vld, logic [3:0] lst, logic [7:0] dst,
                         logic [63:0] dat, logic rdy);
        enable         = en;
        ifc.in_tvalid  = vld;
        ifc.in_tlast   = lst;
        ifc.in_tdest   = dst;
        ifc.in_tdata   = dat;
        ifc.out_tready = rdy;
    endtask

    task automatic check(string nm, logic [26:0] exp);
        logic [26:0] act;
        act = {ifc.out_tvalid, ifc.out_tlast, ifc.out_tdata, ifc.in_tready, busy, grant};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {vld,lst,dat,rdy,busy,grant}=%h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_val(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One cycle: inputs applied after posedge, outputs compared on the negedge.
    task automatic run_vec(vec_t v);
        drive(v.en, v.vld, v.lst, v.dst, v.dat, v.rdy);
        @(negedge clk);
        check(v.name, v.exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [26:0] z;
        int          beat [4];
        logic [3:0]  rdy_s;
        logic [3:0]  lst;
        logic [63:0] dat;
        z = '0;

        // Single request: port 1, three beats, rr_ptr starts at 0.
        tbl.push_back(mkv("t1_req",  1, 4'b0010, 4'b0000, 8'h08, 64'h0000_0000_00A1_0000, 1, z));
        tbl.push_back(mkv("t1_b1",   1, 4'b0010, 4'b0000, 8'h08, 64'h0000_0000_00A1_0000, 1, ex(1, 0, 16'h00A1, 4'b0010, 1, 4'b0010)));
        tbl.push_back(mkv("t1_b2",   1, 4'b0010, 4'b0000, 8'h08, 64'h0000_0000_00A2_0000, 1, ex(1, 0, 16'h00A2, 4'b0010, 1, 4'b0010)));
        tbl.push_back(mkv("t1_b3",   1, 4'b0010, 4'b0010, 8'h08, 64'h0000_0000_00A3_0000, 1, ex(1, 1, 16'h00A3, 4'b0010, 1, 4'b0010)));
        tbl.push_back(mkv("t1_idle", 1, 4'b0000, 4'b0000, 8'h00, 64'h0, 1, z));
        // Destination filter: port 0 tdest=1 never served; port 3 single-beat, served twice with a bubble.
        tbl.push_back(mkv("f_req",    1, 4'b1001, 4'b1001, 8'h81, 64'h00D3_0000_0000_00B0, 1, z));
        tbl.push_back(mkv("f_b1",     1, 4'b1001, 4'b1001, 8'h81, 64'h00D3_0000_0000_00B0, 1, ex(1, 1, 16'h00D3, 4'b1000, 1, 4'b1000)));
        tbl.push_back(mkv("f_bubble", 1, 4'b1001, 4'b1001, 8'h81, 64'h00D3_0000_0000_00B0, 1, z));
        tbl.push_back(mkv("f_b2",     1, 4'b1001, 4'b1001, 8'h81, 64'h00D3_0000_0000_00B0, 1, ex(1, 1, 16'h00D3, 4'b1000, 1, 4'b1000)));
        tbl.push_back(mkv("f_idle",   1, 4'b0000, 4'b0000, 8'h00, 64'h0, 1, z));
        // Backpressure: port 2, out_tready 1,0,0,1.
        tbl.push_back(mkv("bp_req",   1, 4'b0100, 4'b0000, 8'h20, 64'h0000_00C1_0000_0000, 1, z));
        tbl.push_back(mkv("bp_b1",    1, 4'b0100, 4'b0000, 8'h20, 64'h0000_00C1_0000_0000, 1, ex(1, 0, 16'h00C1, 4'b0100, 1, 4'b0100)));
        tbl.push_back(mkv("bp_hold1", 1, 4'b0100, 4'b0100, 8'h20, 64'h0000_00C2_0000_0000, 0, ex(1, 1, 16'h00C2, 4'b0000, 1, 4'b0100)));
        tbl.push_back(mkv("bp_hold2", 1, 4'b0100, 4'b0100, 8'h20, 64'h0000_00C2_0000_0000, 0, ex(1, 1, 16'h00C2, 4'b0000, 1, 4'b0100)));
        tbl.push_back(mkv("bp_b2",    1, 4'b0100, 4'b0100, 8'h20, 64'h0000_00C2_0000_0000, 1, ex(1, 1, 16'h00C2, 4'b0100, 1, 4'b0100)));
        tbl.push_back(mkv("bp_idle",  1, 4'b0000, 4'b0000, 8'h00, 64'h0, 1, z));
        // rr_ptr=3 wraps to port 0; tvalid gap and tdest change mid-packet.
        tbl.push_back(mkv("vd_req",  1, 4'b0001, 4'b0000, 8'h02, 64'h0000_0000_0000_00E1, 1, z));
        tbl.push_back(mkv("vd_b1",   1, 4'b0001, 4'b0000, 8'h02, 64'h0000_0000_0000_00E1, 1, ex(1, 0, 16'h00E1, 4'b0001, 1, 4'b0001)));
        tbl.push_back(mkv("vd_gap",  1, 4'b0000, 4'b0000, 8'h03, 64'h0000_0000_0000_00E2, 1, ex(0, 0, 16'h00E2, 4'b0001, 1, 4'b0001)));
        tbl.push_back(mkv("vd_b2",   1, 4'b0001, 4'b0001, 8'h03, 64'h0000_0000_0000_00E2, 1, ex(1, 1, 16'h00E2, 4'b0001, 1, 4'b0001)));
        tbl.push_back(mkv("vd_idle", 1, 4'b0000, 4'b0000, 8'h00, 64'h0, 1, z));
        // Enable masking: blocked 10 cycles, granted once, enable dropped mid-packet.
        for (int i = 0; i < 10; i++)
            tbl.push_back(mkv("en_blocked", 0, 4'b0010, 4'b0000, 8'h08, 64'h0000_0000_00F1_0000, 1, z));
        tbl.push_back(mkv("en_req",  1, 4'b0010, 4'b0000, 8'h08, 64'h0000_0000_00F1_0000, 1, z));
        tbl.push_back(mkv("en_b1",   0, 4'b0010, 4'b0000, 8'h08, 64'h0000_0000_00F1_0000, 1, ex(1, 0, 16'h00F1, 4'b0010, 1, 4'b0010)));
        tbl.push_back(mkv("en_b2",   0, 4'b0010, 4'b0010, 8'h08, 64'h0000_0000_00F2_0000, 1, ex(1, 1, 16'h00F2, 4'b0010, 1, 4'b0010)));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mkv("en_post", 0, 4'b0010, 4'b0000, 8'h08, 64'h0000_0000_00F1_0000, 1, z));

        // Reset state, held with a request pending.
        reset = 1'b0;
`ifdef EGRESS_ARB_PKT_CNT_EN
        pkt_cnt_clr = 1'b0;
`endif
        drive(1, 4'b0010, 4'b0000, 8'h08, 64'h0, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", z);
        @(posedge clk);
        #1;
        reset = 1'b1;

        foreach (tbl[i]) run_vec(tbl[i]);
`ifdef EGRESS_ARB_PKT_CNT_EN
        check_val("pkt_cnt_after_table", 32'(pkt_cnt), 32'd6);
`endif

        // Reset mid-packet: rr_ptr is 2 here; port 2 sends beat 2 of 4 when reset hits.
        run_vec(mkv("rst_req", 1, 4'b0100, 4'b0000, 8'h20, 64'h0000_0021_0000_0000, 1, z));
        run_vec(mkv("rst_b1",  1, 4'b0100, 4'b0000, 8'h20, 64'h0000_0021_0000_0000, 1, ex(1, 0, 16'h0021, 4'b0100, 1, 4'b0100)));
        drive(1, 4'b0100, 4'b0000, 8'h20, 64'h0000_0022_0000_0000, 1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_async", z);
`ifdef EGRESS_ARB_PKT_CNT_EN
        check_val("pkt_cnt_after_reset", 32'(pkt_cnt), 32'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;
        // Ports 1 and 3 request: a cleared rr_ptr picks port 1.
        run_vec(mkv("rst_after_req", 1, 4'b1010, 4'b1010, 8'h88, 64'h0033_0000_0031_0000, 1, z));
        run_vec(mkv("rst_after_b",   1, 4'b1010, 4'b1010, 8'h88, 64'h0033_0000_0031_0000, 1, ex(1, 1, 16'h0031, 4'b0010, 1, 4'b0010)));
        run_vec(mkv("rst_after_idl", 1, 4'b0000, 4'b0000, 8'h00, 64'h0, 1, z));

        // Round-robin fairness: all ports stream 2-beat packets; expect 0,1,2,3,0 with one bubble each.
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) beat[i] = 0;
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 3; c++) begin
                int p;
                p = k % 4;
                dat = '0;
                lst = '0;
                for (int i = 0; i < 4; i++) begin
                    dat[i*16 +: 16] = 16'(i*16 + beat[i]);
                    lst[i]          = (beat[i] == 1);
                end
                drive(1, 4'b1111, lst, 8'hAA, dat, 1);
                @(negedge clk);
                if (c == 0)
                    check($sformatf("rr_pkt%0d_bubble", k), z);
                else
                    check($sformatf("rr_pkt%0d_beat%0d", k, c - 1),
                          ex(1, (c == 2), 16'(p*16 + c - 1), 4'(1 << p), 1, 4'(1 << p)));
                rdy_s = ifc.in_tready;
                @(posedge clk);
                #1;
                for (int i = 0; i < 4; i++)
                    if (rdy_s[i]) beat[i] = (beat[i] == 1) ? 0 : 1;
            end
        end
        drive(1, 4'b0000, 4'b0000, 8'h00, 64'h0, 1);
`ifdef EGRESS_ARB_PKT_CNT_EN
        @(negedge clk);
        check_val("pkt_cnt_rr", 32'(pkt_cnt), 32'd5);
        pkt_cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        pkt_cnt_clr = 1'b0;
        @(negedge clk);
        check_val("pkt_cnt_clr", 32'(pkt_cnt), 32'd0);
`endif
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/egress_arbiter.md
Name: egress_arbiter

Overview:
- Per-egress-port packet arbiter for the packet switch; one instance per egress port, four in total.
- Selects one of NUM_INGRESS ingress AXI-Stream ports whose tdest matches PORT_ID, using round-robin. Holds the grant for a whole packet until the tlast beat is accepted.
- Muxes the granted stream onto the egress port. Honours the switch's egress-mask bit for this port.

Parameters:
- NUM_INGRESS, 4: number of ingress ports arbitrated.
- DATA_WIDTH, 16: tdata width.
- DEST_WIDTH, 2: tdest width.
- PORT_ID, 0: tdest value served by this instance; must be < 2**DEST_WIDTH.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  egress-mask bit for this port; low blocks new grants.
- in_tdata  in  NUM_INGRESS*DATA_WIDTH  ingress data, port i at slice i.
- in_tdest  in  NUM_INGRESS*DEST_WIDTH  ingress destination per port.
- in_tvalid  in  NUM_INGRESS  ingress valid per port.
- in_tlast  in  NUM_INGRESS  ingress last per port.
- in_tready  out  NUM_INGRESS  ready returned per port; top level ORs across the four arbiters.
- out_tdata  out  DATA_WIDTH  egress data.
- out_tvalid  out  1  egress valid.
- out_tlast  out  1  egress last.
- out_tready  in  1  egress ready.
- busy  out  1  high while a packet is granted.
- grant  out  NUM_INGRESS  one-hot current grant; zero when idle.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, grant=0, rr_ptr=0, busy=0. Outputs out_tvalid=0, out_tlast=0, out_tdata=0, in_tready=0.
- Request: req[i] = in_tvalid[i] && in_tdest[i]==PORT_ID && enable.
- States: IDLE, BUSY.
- IDLE:
  - out_tvalid=0, out_tdata=0, out_tlast=0, in_tready all 0.
  - If any req: pick the first i with req[i], scanning rr_ptr, rr_ptr+1, ... mod NUM_INGRESS.
  - Register grant=onehot(i), go to BUSY.
  - Arbitration latency: one cycle from request to first egress beat valid.
- BUSY, with g = granted index:
  - out_tvalid=in_tvalid[g], out_tdata=in_tdata[g], out_tlast=in_tlast[g].
  - in_tready[g]=out_tready; all other in_tready=0. Combinational pass-through, zero beat latency.
  - Beat accepted when out_tvalid && out_tready.
  - On an accepted beat with out_tlast=1: go to IDLE, rr_ptr <= (g+1) mod NUM_INGRESS, grant <= 0.
  - IDLE always lasts at least one cycle between packets (one bubble).
- Boundary conditions:
  - tdest is evaluated only in IDLE; tdest changes mid-packet are ignored.
  - enable deasserted in BUSY: the current packet completes; no new grant until enable=1.
  - Single-beat packet (tlast on first beat): BUSY for exactly one accepted beat, then IDLE.
  - Granted source drops tvalid mid-packet: stay in BUSY, out_tvalid=0, grant held indefinitely.
  - out_tready=0: hold; no beat consumed, no state change.
  - rr_ptr wrap: NUM_INGRESS-1 wraps to 0.
  - Reset mid-packet: immediate return to IDLE; packet truncated, no tlast emitted; upstream is responsible for the stale remainder.
  - All requesters active continuously: each port is served once per NUM_INGRESS packets. Starvation-free.

Optional Feature:
- Macro: EGRESS_ARB_PKT_CNT_EN.
- Defined:
  - Adds ports pkt_cnt (out, 16) and pkt_cnt_clr (in, 1).
  - pkt_cnt increments on every accepted tlast beat and saturates at 16'hFFFF.
  - pkt_cnt_clr=1 zeroes it next cycle; clear takes priority over a simultaneous increment.
  - Reset value 0.
- Undefined: ports absent, no counter logic.

Decomposition:
- Shared package gains NUM_INGRESS_PORTS, NUM_EGRESS_PORTS, AXIS_DATA_WIDTH, AXIS_DEST_WIDTH and an arb_state_t enum {ARB_IDLE, ARB_BUSY}.
- The existing axis_d_source_t / axis_sink_t typedefs are reused at the packet_switch level, which flattens them onto these ports.
- Sub-module rr_pick: combinational round-robin first-set-after-pointer, inputs req and rr_ptr, output one-hot plus index. Reusable by future schedulers.

Test Plan:
- Single request, PORT_ID=2: port 1 sends 3 beats (tdest=2, data 0xA1,0xA2,0xA3, last on 3rd), out_tready=1 → grant=4'b0010 after 1 cycle; out_tdata sequence A1,A2,A3 on consecutive cycles; then IDLE with busy=0.
- Round-robin fairness: all 4 ports continuously requesting 2-beat packets → grant order 0,1,2,3,0; each packet followed by exactly 1 idle cycle.
- Destination filtering: port 0 tdest=1, port 3 tdest=0, PORT_ID=0 → only port 3 granted; in_tready[0] stays 0 throughout.
- Enable masking: enable=0 with requests pending → no grant for 10 cycles. Drop enable mid-packet → the packet finishes, then no further grants.
- Backpressure: out_tready toggles 1,0,0,1 on a 2-beat packet → data held stable while not ready; in_tready[g] mirrors out_tready; packet completes on the 4th cycle.
- Reset mid-packet: assert reset on beat 2 of 4 → out_tvalid=0, busy=0, grant=0 asynchronously. After release, next grant starts from rr_ptr=0. With EGRESS_ARB_PKT_CNT_EN, pkt_cnt=0.
